// File: rtl/seq_stream_pkg.sv
// Shared types and constants for the detector sequencer.
// Optional match counter is enabled by defining SEQ_STREAM_MATCH_CNT_EN.
package seq_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 20;
  localparam int DEPTH_DEF = 7;

  // Width needed to count 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_stream_pattern_ram.sv
// Pattern store: synchronous write, asynchronous read, contents survive reset.
module pattern_ram
  import seq_stream_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_stream_ctrl.sv
// Streams a stored word MSB-first into the detector and collects its w output.
// Define SEQ_STREAM_MATCH_CNT_EN to add the match_cnt output.
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_sel,
  output logic              a,
  output logic              det_rst,
  input  logic              w,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  result
`ifdef SEQ_STREAM_MATCH_CNT_EN
  ,output logic [cnt_w(WIDTH)-1:0] match_cnt
`endif
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sreg, rd_word;
  logic             ready, sel_ok, accept, reject, we;
  logic             det_rst_nx, busy_nx, done_nx, err_nx;

  assign ready  = (state == IDLE) || (state == DONE);
  assign sel_ok = {1'b0, word_sel} < DEPTH_L;
  assign accept = ready & start & sel_ok;
  assign reject = ready & start & ~sel_ok;
  assign we     = ready & load_en & ({1'b0, load_addr} < DEPTH_L);

  // Async read means a same-cycle start sees the pre-write word.
  pattern_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (word_sel),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? CLR : IDLE;
      CLR:        state_nx = SHIFT;
      SHIFT:      if (idx == '0) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Decode from the next state so the registered flags line up with the state.
  always_comb begin
    det_rst_nx = (state_nx == CLR);
    busy_nx    = (state_nx == CLR) || (state_nx == SHIFT);
    done_nx    = (state_nx == DONE);
    err_nx     = reject;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      det_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      det_rst <= det_rst_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      err     <= err_nx;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx    <= '0;
      sreg   <= '0;
      result <= '0;
    end else if (accept) begin
      idx    <= IDX_W'(WIDTH - 1);
      sreg   <= rd_word;
      result <= '0;
    end else if (state == SHIFT) begin
      result[idx] <= w;
      idx         <= idx - 1'b1;
    end

  assign a = (state == SHIFT) & sreg[idx];

`ifdef SEQ_STREAM_MATCH_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                       match_cnt <= '0;
    else if (accept)               match_cnt <= '0;
    else if ((state == SHIFT) && w) match_cnt <= match_cnt + 1'b1;
`endif

endmodule

// File: doc/seq_stream_ctrl.md
# seq_stream_ctrl

Sequencer that drives the serial sequence detector. It holds a small pattern memory of test words and, on command, resets the detector. It then streams one selected word into the detector's `a` input MSB-first, one bit per clock, and collects the detector's `w` output into a parallel result word. It sits between a host or loader and the detector, replacing bench-side bit-banging with a synthesizable start/done controller.

## Interface
- `WIDTH`, 20: bits per pattern word and per result word.
- `DEPTH`, 7: number of pattern words stored.
- `ADDR_W`, 3: address width; must satisfy 2**ADDR_W >= DEPTH.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `load_en` input 1: write `load_data` to `load_addr` this cycle.
- `load_addr` input ADDR_W: pattern write address.
- `load_data` input WIDTH: pattern write data.
- `start` input 1: request a run of word `word_sel`.
- `word_sel` input ADDR_W: word to stream, sampled with `start`.
- `a` output 1: serial bit to the detector.
- `det_rst` output 1: synchronous clear pulse to the detector.
- `w` input 1: detector output, Mealy on current `a`.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse; `result` is valid.
- `err` output 1: one-cycle pulse; `start` was rejected.
- `result` output WIDTH: captured `w` bits; bit WIDTH-1 is the first captured.

## Operation
- States: IDLE, CLR, SHIFT, DONE.
- IDLE:
  - `start` with `word_sel` < DEPTH: latch the word into the shift register, clear `result` to 0, go to CLR.
  - `start` with `word_sel` >= DEPTH: pulse `err` next cycle and stay in IDLE.
- CLR: `det_rst`=1, `a`=0, bit index loaded with WIDTH-1. Go to SHIFT.
- SHIFT:
  - `a` = word[idx].
  - At the clock edge, `result[idx]` <= `w`.
  - idx decrements each cycle; after idx=0, go to DONE.
- DONE: `done`=1, `busy`=0. A `start` in this cycle is accepted exactly as in IDLE. Otherwise go to IDLE.
- Pattern writes:
  - `load_en` is honoured only in IDLE and DONE and ignored while `busy`=1.
  - Writes with `load_addr` >= DEPTH are dropped.
- `start` and `load_en` in the same cycle: the read happens before the write, so the run uses the pre-write contents.
- `start` while `busy`=1 is ignored, with no `err`.
- `result` holds its value from DONE until the next accepted `start`.

## Timing
- Reset values: state=IDLE, `a`=0, `det_rst`=0, `busy`=0, `done`=0, `err`=0, `result`=0. Pattern memory is not reset and keeps its contents across `rst`.
- Accepted `start` sampled at edge E0:
  - CLR occupies cycle 1.
  - SHIFT occupies cycles 2..WIDTH+1.
  - `done` is high in cycle WIDTH+2, i.e. 22 for WIDTH=20.
  - `busy` is high in cycles 1..WIDTH+1.
- `err` is high in cycle 1 after a rejected `start`.
- All outputs are registered except `a`, which is decoded directly from the shift register and the state.
- Reset mid-run: everything returns to reset values immediately and no `done` is issued. The next run needs a fresh `start`.

## Configuration
- `SEQ_STREAM_MATCH_CNT_EN` defined:
  - Adds output `match_cnt` of width $clog2(WIDTH+1).
  - `match_cnt` is cleared on accepted `start`, increments on every SHIFT cycle with `w`=1, and is valid with `done`.
  - Reset value is 0.
- Not defined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- `seq_stream_pkg` holds:
  - The state enum (IDLE, CLR, SHIFT, DONE).
  - Default `WIDTH`/`DEPTH` constants.
  - The count-width function.
- Sub-module `pattern_ram`: DEPTH x WIDTH, synchronous write, asynchronous read, no reset.
- The FSM, bit index counter, shift register and result capture are in `seq_stream_ctrl`.

## Test plan
Tests 1–5 use an echo stub detector (`w`=`a`); test 6 uses the real detector.
1. Load word 0 = 20'hA5A5A, then start with `word_sel`=0 -> `det_rst` high in cycle 1. `a` follows 1,0,1,0,0,1,... from cycle 2. `done` pulses in cycle 22 with `result`=20'hA5A5A.
2. Start with `word_sel`=7 -> `err` high in cycle 1 only. `busy`, `done` and `det_rst` stay 0, and `result` is unchanged.
3. Assert `rst` in cycle 10 of a run -> outputs return to 0 at once and no `done` appears. Re-start the same word -> same `result` as an uninterrupted run, showing memory is retained.
4. During a run, assert `start` with `word_sel`=1 and `load_en` to word 0 with 20'h00000 -> both are ignored. `result` matches the original word, and a follow-up run of word 0 returns its old value.
5. With `SEQ_STREAM_MATCH_CNT_EN`, run word 20'hFFFFF -> `match_cnt`=20 at `done`. Run 20'h00001 -> `match_cnt`=1.
6. Back-to-back: `start` in the DONE cycle -> CLR follows immediately with no IDLE cycle, and the second `done` arrives 22 cycles after the first.
